// File: rtl/parking_sensor_array.sv
// Polls N_CH SPI occupancy sensors once per poll period and debounces each channel's occupancy bit.
// A frame registers in the cycle HOLD ends. Events fire in that same cycle. There is no backpressure; a tick that arrives mid-scan is dropped and sets overrun.
module parking_sensor_array #(
  parameter int N_CH      = 4,
  parameter int POLL_DIV  = 3333333,
  parameter int SCLK_HALF = 50,
  parameter int SETUP     = 1500,
  parameter int BYTE_GAP  = 1000,
  parameter int DEBOUNCE  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            miso,
  output logic [N_CH-1:0] ss_n,
  output logic            sclk,
  output logic            mosi,
  output logic [N_CH-1:0] parked,
  output logic            evt_valid,
  output logic [3:0]      evt_ch,
  output logic            evt_parked,
  output logic            frame_valid,
  output logic [39:0]     frame_data,
  output logic [3:0]      frame_ch,
  output logic            busy,
  output logic            overrun
);

  localparam int PW    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int T_MAX = (SETUP > 2*SCLK_HALF) ? ((SETUP > BYTE_GAP) ? SETUP : BYTE_GAP)
                                               : ((2*SCLK_HALF > BYTE_GAP) ? 2*SCLK_HALF : BYTE_GAP);
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_SHIFT, S_GAP, S_HOLD, S_DESEL} state_t;

  state_t          state;
  logic [PW-1:0]   poll_cnt;
  logic            tick;
  logic [TW-1:0]   tmr;
  logic [5:0]      bit_cnt;
  logic [CW-1:0]   ch;
  logic [CW-1:0]   ch_nxt;
  logic [39:0]     shreg;
  logic [3:0]      db_cnt [N_CH];

  assign tick   = (poll_cnt == PW'(POLL_DIV - 1));
  assign ch_nxt = ch + 1'b1;
  assign mosi   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) poll_cnt <= '0;
    else     poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tmr         <= '0;
      bit_cnt     <= '0;
      ch          <= '0;
      shreg       <= '0;
      ss_n        <= '1;
      sclk        <= 1'b0;
      parked      <= '0;
      evt_valid   <= 1'b0;
      evt_ch      <= '0;
      evt_parked  <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_ch    <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      evt_valid   <= 1'b0;
      if (tick && busy) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_SEL;
            busy  <= 1'b1;
            ch    <= '0;
            tmr   <= '0;
            ss_n  <= ~(N_CH'(1));
          end
        end

        S_SEL: begin
          if (tmr == TW'(SETUP - 1)) begin
            tmr     <= '0;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        // Mode 0: MISO is captured on the same edge that raises sclk.
        S_SHIFT: begin
          if (tmr == TW'(SCLK_HALF - 1)) begin
            sclk  <= 1'b1;
            shreg <= {shreg[38:0], miso};
          end
          if (tmr == TW'(2*SCLK_HALF - 1)) begin
            sclk    <= 1'b0;
            tmr     <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 6'd39)
              state <= S_HOLD;
            else if (bit_cnt[2:0] == 3'd7 && BYTE_GAP > 0)
              state <= S_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_GAP: begin
          if (tmr == TW'(BYTE_GAP - 1)) begin
            tmr   <= '0;
            state <= S_SHIFT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_HOLD: begin
          if (tmr == TW'(SETUP - 1)) begin
            tmr         <= '0;
            state       <= S_DESEL;
            ss_n        <= '1;
            frame_valid <= 1'b1;
            frame_data  <= shreg;
            frame_ch    <= 4'(ch);
            // Occupancy is the first bit received; flip only after DEBOUNCE disagreeing frames in a row.
            if (shreg[39] == parked[ch]) begin
              db_cnt[ch] <= '0;
            end else if (db_cnt[ch] == 4'(DEBOUNCE - 1)) begin
              db_cnt[ch] <= '0;
              parked[ch] <= shreg[39];
              evt_valid  <= 1'b1;
              evt_ch     <= 4'(ch);
              evt_parked <= shreg[39];
            end else begin
              db_cnt[ch] <= db_cnt[ch] + 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_DESEL: begin
          if (tmr == TW'(SETUP - 1)) begin
            tmr <= '0;
            if (ch == CW'(N_CH - 1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              ch    <= ch_nxt;
              ss_n  <= ~(N_CH'(1) << ch_nxt);
              state <= S_SEL;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_sensor_array.sv
// Scoreboarded bench: a sensor model on the shared bus, directed scans, an overrun instance and a mid-frame reset.
module tb_parking_sensor_array;
  localparam int H = 2, SET = 4, GAP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, miso = 1'b0, miso2 = 1'b0;
  logic [1:0]  ss_n, parked, ss_n2, parked2;
  logic        sclk, mosi, evt_valid, evt_parked, frame_valid, busy, overrun;
  logic        sclk2, mosi2, evt_valid2, evt_parked2, frame_valid2, busy2, overrun2;
  logic [3:0]  evt_ch, frame_ch, evt_ch2, frame_ch2;
  logic [39:0] frame_data, frame_data2;

  parking_sensor_array #(.N_CH(2), .POLL_DIV(2000), .SCLK_HALF(H), .SETUP(SET),
                         .BYTE_GAP(GAP), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .miso(miso), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .parked(parked), .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_parked(evt_parked),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_ch(frame_ch),
    .busy(busy), .overrun(overrun));

  parking_sensor_array #(.N_CH(2), .POLL_DIV(300), .SCLK_HALF(H), .SETUP(SET),
                         .BYTE_GAP(GAP), .DEBOUNCE(3)) dut_ov (
    .clk(clk), .rst(rst), .miso(miso2), .ss_n(ss_n2), .sclk(sclk2), .mosi(mosi2),
    .parked(parked2), .evt_valid(evt_valid2), .evt_ch(evt_ch2), .evt_parked(evt_parked2),
    .frame_valid(frame_valid2), .frame_data(frame_data2), .frame_ch(frame_ch2),
    .busy(busy2), .overrun(overrun2));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [3:0] ch; logic [39:0] data; } frm_t;
  typedef struct { logic [3:0] ch; logic p; } evt_t;
  frm_t fq[$];
  evt_t eq[$];

  task automatic push_frame(input logic [3:0] c, input logic [39:0] d);
    frm_t f;
    f.ch = c; f.data = d;
    fq.push_back(f);
  endtask

  task automatic push_evt(input logic [3:0] c, input logic p);
    evt_t e;
    e.ch = c; e.p = p;
    eq.push_back(e);
  endtask

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    rst_seen <= rst;
    cyc      <= rst ? 0 : cyc + 1;
  end

  // Sensor model: each selected sensor shifts out its frame MSB first, advancing after every sclk rise.
  logic [39:0] fr [2];
  int   k = 0;
  logic sclk_q = 1'b0;
  always @(negedge clk) begin
    if (&ss_n) k = 0;
    else if (sclk && !sclk_q) k = k + 1;
    sclk_q = sclk;
    if (!ss_n[0])      miso = (k < 40) ? fr[0][39-k] : 1'b0;
    else if (!ss_n[1]) miso = (k < 40) ? fr[1][39-k] : 1'b0;
    else               miso = 1'b0;
  end

  // Scoreboard monitor for frames and events.
  frm_t fe;
  evt_t ee;
  always @(negedge clk) begin
    if (frame_valid) begin
      if (fq.size() == 0) begin
        checks++; failures++;
        $display("FAIL frame_unexpected: got ch %0d data %h, expected no frame", frame_ch, frame_data);
      end else begin
        fe = fq.pop_front();
        chk("frame_ch", 64'(frame_ch), 64'(fe.ch));
        chk("frame_data", 64'(frame_data), 64'(fe.data));
      end
    end
    if (evt_valid) begin
      if (eq.size() == 0) begin
        checks++; failures++;
        $display("FAIL evt_unexpected: got ch %0d parked %0d, expected no event", evt_ch, evt_parked);
      end else begin
        ee = eq.pop_front();
        chk("evt_ch", 64'(evt_ch), 64'(ee.ch));
        chk("evt_parked", 64'(evt_parked), 64'(ee.p));
      end
    end
  end

  // Bus timing monitor: select exclusivity, select length, sclk edge count, byte gaps.
  int   low_len = 0, hi_len = 0, edges = 0, gaps = 0, run = 0;
  logic sel_p = 1'b0, sclk_p = 1'b0, sel;
  always @(negedge clk) begin
    sel = ~&ss_n;
    if (rst_seen) begin
      low_len = 0; hi_len = 0; edges = 0; gaps = 0; run = 0; sel_p = 1'b0; sclk_p = 1'b0;
    end else begin
      chk("bus_rules", {62'd0, $countones(~ss_n) <= 1, sel || !sclk}, 64'd3);
      if (sel) begin
        if (!sel_p && !ss_n[1]) chk("inter_channel_idle", 64'(hi_len), 64'(SET));
        low_len++;
        if (sclk != sclk_p) edges++;
        if (sclk && !sclk_p) begin
          if (run == H + GAP) gaps++;
          run = 0;
        end else if (!sclk) begin
          run++;
        end
        hi_len = 0;
      end else begin
        if (sel_p) begin
          chk("ss_low_len", 64'(low_len), 64'd192);
          chk("sclk_edges", 64'(edges), 64'd80);
          chk("byte_gaps", 64'(gaps), 64'd4);
          low_len = 0; edges = 0; gaps = 0; run = 0;
        end
        hi_len++;
      end
      sel_p = sel; sclk_p = sclk;
    end
  end

  // Overrun instance: frames must still alternate ch0, ch1 with all-zero data.
  logic [3:0] exp2 = 4'd0;
  int n2 = 0;
  always @(negedge clk) begin
    if (rst_seen) exp2 = 4'd0;
    else if (frame_valid2) begin
      chk("ov_frame_ch", 64'(frame_ch2), 64'(exp2));
      chk("ov_frame_data", 64'(frame_data2), 64'd0);
      exp2 = exp2 ^ 4'd1;
      n2++;
    end
  end

  initial begin
    while (cyc != 599) @(negedge clk);
    chk("overrun_before_second_tick", 64'(overrun2), 64'd0);
    while (cyc != 700) @(negedge clk);
    chk("overrun_set", 64'(overrun2), 64'd1);
  end

  task automatic wait_busy(input logic lvl, input int lim, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (busy == lvl) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s: busy stayed %0d for %0d cycles, expected %0d", name, !lvl, lim, lvl);
    end
  endtask

  localparam logic [39:0] C1 = 40'h80_1234_5678;
  logic [39:0] t_fr0 [7] = '{40'h0, 40'hA5_0000_00FF, 40'hA5_0000_00FF, 40'h7F_FFFF_FFFF,
                             40'hC0_FFEE_0001, 40'h80_0000_0000, 40'hFF_FFFF_FFFF};
  logic [39:0] t_fr1 [7] = '{40'h0, C1, C1, C1, C1, C1, C1};
  logic [1:0]  t_park [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11};
  int          t_evt  [7] = '{-1, -1, -1, 1, -1, -1, 0};

  initial begin
    fr[0] = '0; fr[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 64'(ss_n), 64'd3);
    chk("rst_ctrl", {56'd0, sclk, mosi, parked, evt_valid, frame_valid, busy, overrun}, 64'd0);
    chk("rst_frame", {20'd0, frame_data, frame_ch}, 64'd0);
    chk("rst_evt", {59'd0, evt_ch, evt_parked}, 64'd0);
    rst = 1'b0;

    for (int s = 0; s < 7; s++) begin
      fr[0] = t_fr0[s]; fr[1] = t_fr1[s];
      push_frame(4'd0, t_fr0[s]);
      push_frame(4'd1, t_fr1[s]);
      if (t_evt[s] >= 0) push_evt(4'(t_evt[s]), 1'b1);
      wait_busy(1'b1, 2100, "scan_start");
      if (s == 0) begin
        chk("first_tick_cycle", 64'(cyc), 64'd2000);
        chk("ss_n_at_start", 64'(ss_n), 64'd2);
      end
      wait_busy(1'b0, 500, "scan_end");
      chk("parked_after_scan", 64'(parked), 64'(t_park[s]));
      chk("frame_data_hold", 64'(frame_data), 64'(t_fr1[s]));
    end

    chk("overrun_main_clear", 64'(overrun), 64'd0);
    chk("overrun_sticky", 64'(overrun2), 64'd1);

    // Abort a ch0 frame at bit 20 with a one-cycle reset.
    fr[0] = 40'hFF_FFFF_FFFF; fr[1] = '0;
    wait_busy(1'b1, 2100, "abort_scan_start");
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
        @(negedge clk);
        if (!ss_n[0] && k == 20) hit = 1'b1;
      end
      chk("reached_bit20", 64'(hit), 64'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss_n", 64'(ss_n), 64'd3);
    chk("abort_ctrl", {58'd0, sclk, parked, busy, frame_valid, evt_valid}, 64'd0);
    chk("abort_frame_data", 64'(frame_data), 64'd0);
    rst = 1'b0;
    fr[0] = '0;
    push_frame(4'd0, 40'h0);
    push_frame(4'd1, 40'h0);
    wait_busy(1'b1, 2100, "restart_scan_start");
    chk("restart_cycle", 64'(cyc), 64'd2000);
    wait_busy(1'b0, 500, "restart_scan_end");
    chk("parked_after_restart", 64'(parked), 64'd0);

    repeat (5) @(negedge clk);
    chk("frames_left", 64'(fq.size()), 64'd0);
    chk("events_left", 64'(eq.size()), 64'd0);
    chk("ov_frames_seen", 64'(n2 >= 20), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parking_sensor_array.md
# parking_sensor_array

Multi-channel parking occupancy poller that replaces the single-joystick sensor path. It owns an SPI master that reads a 5-byte (40-bit) frame from each of `N_CH` PmodJSTK-style sensors in turn, once per poll period, over a shared SCLK/MISO bus with per-channel active-low selects. Each channel's occupancy bit is debounced over consecutive frames, and every debounced change is reported as a one-cycle event to the meter/display logic.

## Interface
- `N_CH`, 4: number of sensor channels (1..16).
- `POLL_DIV`, 3333333: clocks per poll period (30 Hz at 100 MHz).
- `SCLK_HALF`, 50: clocks per SCLK half-period (1 MHz at 100 MHz).
- `SETUP`, 1500: SS-to-first-edge, last-edge-to-SS-release, and inter-channel idle, in clocks.
- `BYTE_GAP`, 1000: extra SCLK-low clocks after bits 8, 16, 24 and 32.
- `DEBOUNCE`, 3: consecutive agreeing frames required to change a channel's `parked` bit (1..15).

Ports:
- `clk`, in, 1: system clock; all logic on its rising edge.
- `rst`, in, 1: synchronous reset, active high.
- `miso`, in, 1: shared sensor data in.
- `ss_n`, out, N_CH: per-channel select, active low; at most one bit low at a time.
- `sclk`, out, 1: SPI clock, mode 0, idle low.
- `mosi`, out, 1: constant 0.
- `parked`, out, N_CH: debounced occupancy per channel.
- `evt_valid`, out, 1: one-cycle pulse on a debounced change.
- `evt_ch`, out, 4: channel of the event; valid with `evt_valid`.
- `evt_parked`, out, 1: new `parked` value of the event channel.
- `frame_valid`, out, 1: one-cycle pulse when a frame completes.
- `frame_data`, out, 40: last frame, first bit received in bit 39; holds between frames.
- `frame_ch`, out, 4: channel of `frame_data`.
- `busy`, out, 1: high while a scan is in progress.
- `overrun`, out, 1: sticky; set when a poll tick arrives while `busy`.

## Operation
- Poll counter runs from 0 to `POLL_DIV`-1 and wraps. The wrap cycle is the poll tick.
- A tick while idle starts a scan of channels 0..N_CH-1 in order. A tick while `busy` is dropped and sets `overrun`.
- FSM: IDLE -> SEL (ss_n[ch] low, SETUP clocks) -> SHIFT (one bit) -> GAP (after bits 8/16/24/32 only) -> SHIFT ... -> HOLD (SETUP clocks, ss_n still low) -> DESEL (all ss_n high, SETUP clocks). DESEL goes to SEL for ch+1, or to IDLE after the last channel.
- Bit timing: `sclk` low for SCLK_HALF clocks, then high for SCLK_HALF clocks. MISO is registered in the cycle `sclk` goes high. Shifting is MSB-first into a 40-bit register.
- Occupancy sample = `frame_data[39]`, the first bit received.
- Debounce per channel uses a 4-bit counter.
  - If sample == `parked[ch]`: counter cleared.
  - Otherwise: counter increments. When it reaches DEBOUNCE, `parked[ch]` flips, the counter clears, and an event is emitted.
- Frame completion happens in the cycle leaving HOLD. In that cycle `frame_valid`, `frame_data`, `frame_ch`, the debounce update and any `evt_*` all register together.
- Channels are processed sequentially, so two channels can never generate events in the same cycle. No event queue is needed.

## Timing
- Reset values:
  - `ss_n` all 1; `sclk`, `mosi`, `parked`, `evt_valid`, `frame_valid`, `busy`, `overrun` all 0.
  - `frame_data`, `frame_ch`, `evt_ch`, `evt_parked` all 0.
  - Poll counter 0; all debounce counters 0; FSM in IDLE.
- First tick comes `POLL_DIV` clocks after `rst` deasserts.
- `busy` and `ss_n[0]` go low in the cycle after the tick.
- SS-low duration per channel = 2·SETUP + 80·SCLK_HALF + 4·BYTE_GAP clocks. Each channel is followed by SETUP clocks with all selects high.
- `busy` falls in the cycle after the last DESEL ends.
- Parameters must satisfy N_CH·(3·SETUP + 80·SCLK_HALF + 4·BYTE_GAP) < POLL_DIV. Violations cause `overrun`, not corruption.
- Reset mid-frame: the next cycle shows all reset values, and no `frame_valid` or `evt_valid` is emitted for the aborted frame.
- `rst` overrides a simultaneous tick.

## Test plan
- Test parameters: N_CH=2, POLL_DIV=2000, SCLK_HALF=2, SETUP=4, BYTE_GAP=6, DEBOUNCE=3. SS low = 192 clocks per channel.
- Reset, then idle with miso=0 -> `ss_n`=2'b11 and `sclk`=0 until cycle 2000. `ss_n[0]` is low for exactly 192 clocks, then `ss_n[1]` for 192 clocks. Two `frame_valid` pulses with `frame_data`=0. No events.
- Sensor model drives frame 40'h80_1234_5678 on ch1 and 0 on ch0 -> `frame_data`=40'h8012345678 with `frame_ch`=1. Exactly 80 SCLK edges per frame. SCLK low for 6 extra clocks after bits 8, 16, 24 and 32.
- Ch1 bit 39 = 1 for 3 consecutive scans -> `parked`=2'b10 after the 3rd frame. Exactly one `evt_valid` with `evt_ch`=1 and `evt_parked`=1.
- Ch0 pattern 1,1,0,1,1,1 across scans -> no change until the 6th frame, then `parked[0]`=1 with a single event.
- POLL_DIV=300 (scan takes 392 clocks) -> the second tick lands while `busy`, `overrun`=1 and stays 1, and scans still complete in order.
- Assert `rst` for 1 cycle at bit 20 of ch0 -> next cycle `ss_n`=2'b11, `sclk`=0, `parked`=0. No `frame_valid` for the aborted frame. The next scan starts 2000 clocks later.
